mux4_rr_ctrl: RTL and testbench
===============================

Name: mux4_rr_ctrl

Overview:
- Sequential control and capture stage that wraps the team's 8-bit 4:1 mux.
- Arbitrates four requesting channels round-robin and drives the mux `sel[1:0]`.
- Registers the mux output and presents it downstream with a valid/ready handshake.
- Acknowledges the served channel so it can update its data on input a/b/c/d.

Parameters:
- WIDTH, 8, data width of `mux_out` and `dout`; must match the mux data width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  channel requests; bit i means mux input i (0=a, 1=b, 2=c, 3=d) holds valid data
- mux_out  input  WIDTH  combinational output of the 4:1 mux
- sel  output  2  select to the mux, registered
- ack  output  4  one-hot, one-cycle pulse to the channel whose data was captured
- dout  output  WIDTH  captured data, registered
- dout_valid  output  1  `dout` holds unconsumed data
- dout_ready  input  1  downstream accepts `dout` this cycle

Behaviour:
- Clock and reset:
  - Single clock domain; everything updates on the rising edge of `clk`.
  - `rst` is synchronous and active-high; it overrides all other inputs on that edge.
- Reset values:
  - `sel`=0, `ack`=0, `dout`=0, `dout_valid`=0.
  - State=IDLE; internal last-grant pointer `last`=3, so channel 0 has first priority.
- Round-robin pick:
  - Among the asserted `req` bits, choose the first index searching `last+1`, `last+2`, `last+3`, `last` (mod 4).
  - `last` updates to the chosen index only on capture.
- State IDLE:
  - If `req`≠0, register the pick into `sel` and an internal `grant`, then go to SELECT.
  - Otherwise stay; `sel` holds its value.
- State SELECT (mux settles during this cycle):
  - If `req[grant]`=1: `dout`←`mux_out`, `dout_valid`←1, `ack[grant]` pulses high for exactly this one edge-to-edge cycle, `last`←`grant`, go to HOLD.
  - If `req[grant]`=0 (request withdrawn): no capture, no `ack`, go to IDLE.
- State HOLD:
  - `dout` and `dout_valid` are held stable while `dout_ready`=0.
  - On `dout_ready`=1 with `req`≠0 (arbitrated against the updated `last`): `dout_valid`←0, register the new pick into `sel`, go to SELECT.
  - On `dout_ready`=1 with `req`=0: `dout_valid`←0, go to IDLE.
- Latency and throughput:
  - `req` sampled high in IDLE at edge N → `sel` valid after N → `dout_valid`=1 after edge N+1.
  - Sustained throughput is one word per 2 cycles with `dout_ready` tied high.
- Channel contract:
  - A channel keeps `req` and its mux input stable until it sees `ack`.
  - It may drop `req` in the cycle after `ack`.
- Boundary conditions:
  - Simultaneous requests: round-robin order, with no channel served twice while another is pending.
  - Single requester: served every transaction.
  - `dout_ready` high while `dout_valid`=0: ignored.
  - `req` toggling while in HOLD: not sampled until the handshake completes.
  - `rst` mid-operation, in any state: the reset values above on that edge. An in-flight capture is discarded, and no `ack` is issued on the reset edge.
- `ack` is never asserted outside SELECT, and never on more than one bit.

Optional Feature:
- Macro: FIXED_PRIO_EN.
- When defined: the pick is fixed-priority, with channel 0 highest and 3 lowest. `last` is not used.
- When undefined: round-robin as described.
- All other timing, handshake and reset behaviour is identical in both builds.

Test Plan:
- Reset then single request:
  - Stimulus: `rst` 1 cycle; `req`=4'b0100, `c`=8'hA5, `dout_ready`=1.
  - Response: `sel`=2 after the first edge; `dout`=8'hA5, `dout_valid`=1 and `ack`=4'b0100 after the second edge.
- Round-robin fairness:
  - Stimulus: `req`=4'b1111 held, `dout_ready`=1, data a..d = 8'h11/22/33/44.
  - Response: `dout` sequence 11,22,33,44,11; `ack` one-hot per capture.
- Backpressure:
  - Stimulus: capture 8'h5A with `dout_ready`=0 for 5 cycles.
  - Response: `dout`=8'h5A and `dout_valid`=1 stable for 5 cycles, no new `sel`; the word is consumed on the first `dout_ready`=1 cycle.
- Withdrawn request:
  - Stimulus: `req`=4'b0010 for one cycle only.
  - Response: `sel`=1, SELECT finds `req[1]`=0 → IDLE; `dout_valid` and `ack` stay 0.
- Reset mid-HOLD:
  - Stimulus: `dout_valid`=1, `dout`=8'h77, then `rst`=1.
  - Response: next edge `dout`=0, `dout_valid`=0, `sel`=0. With `req`=4'b1001 afterwards, channel 0 is served first.
- FIXED_PRIO_EN build:
  - Stimulus: `req`=4'b1001 held.
  - Response: channel 0 is served on every transaction and channel 3 never. Without the macro, 0 and 3 alternate.

Source files
------------

// File: rtl/mux4_rr_ctrl.sv
// Round-robin arbiter and capture stage in front of an external 8-bit 4:1 mux.
// Define FIXED_PRIO_EN for a fixed-priority pick (channel 0 highest) instead of round-robin.
module mux4_rr_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] mux_out,
    output logic [1:0]       sel,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready
);

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       grant_q, grant_d;
    logic [3:0]       ack_q, ack_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             capture;
    logic [1:0]       pick;

`ifdef FIXED_PRIO_EN
    always_comb begin
        pick = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                pick = 2'(i);
            end
        end
    end
`else
    logic [1:0] last_q, last_d;
    logic [1:0] idx;

    // Scan from farthest to nearest so the first requester after last_q wins.
    always_comb begin
        pick = last_q;
        idx  = last_q;
        for (int k = 4; k >= 1; k--) begin
            idx = last_q + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        last_d = capture ? grant_q : last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 2'd3;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        ack_d   = 4'b0000;
        dout_d  = dout_q;
        valid_d = valid_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    sel_d   = pick;
                    grant_d = pick;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                // The channel may have withdrawn while the mux was settling.
                if (req[grant_q]) begin
                    dout_d  = mux_out;
                    valid_d = 1'b1;
                    ack_d   = 4'b0001 << grant_q;
                    capture = 1'b1;
                    state_d = StHold;
                end else begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (dout_ready) begin
                    valid_d = 1'b0;
                    if (|req) begin
                        sel_d   = pick;
                        grant_d = pick;
                        state_d = StSelect;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 2'd0;
            grant_q <= 2'd0;
            ack_q   <= 4'b0000;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign sel        = sel_q;
    assign ack        = ack_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_ctrl.sv
// Scoreboard bench for mux4_rr_ctrl: bench-side channels and mux, queue-level arbitration model.
// Honours FIXED_PRIO_EN the same way as the design.
module tb_mux4_rr_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [W-1:0] mux_out;
    logic [1:0]   sel;
    logic [3:0]   ack;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;

    logic [W-1:0] ch_data [4];

    always #5 clk = ~clk;

    always_comb mux_out = ch_data[sel];

    mux4_rr_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mux_out    (mux_out),
        .sel        (sel),
        .ack        (ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    typedef struct packed {
        logic [1:0]   ch;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   rd_idx = 0;
    int   total  = 0;
    int   bad    = 0;

    // Per-channel word lists; head advances when the channel sees its ack.
    logic [W-1:0] ch_mem [4][256];
    int           ch_head [4];
    int           ch_tail [4];
    int           mdl_idx [4];
    int           mdl_last;
    logic [3:0]   ack_seen;
    logic         rand_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic add_word(input int ch, input logic [W-1:0] d);
        ch_mem[ch][ch_tail[ch]] = d;
        ch_tail[ch]++;
    endtask

    // Serve every queued word: each time take the next channel in circular order after the
    // last one served (or the lowest-numbered one for fixed priority) that still has words.
    task automatic predict();
        int   rem [4];
        int   n;
        int   p;
        exp_t e;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            rem[i] = ch_tail[i] - mdl_idx[i];
            n += rem[i];
        end
        while (n > 0) begin
            p = -1;
`ifdef FIXED_PRIO_EN
            for (int i = 0; i < 4; i++) begin
                if (p < 0 && rem[i] > 0) p = i;
            end
`else
            for (int k = 1; k <= 4; k++) begin
                if (p < 0 && rem[(mdl_last + k) % 4] > 0) p = (mdl_last + k) % 4;
            end
`endif
            e.ch   = p[1:0];
            e.data = ch_mem[p][mdl_idx[p]];
            exp_q.push_back(e);
            mdl_idx[p]++;
            rem[p]--;
            n--;
            mdl_last = p;
        end
    endtask

    task automatic apply_req();
        for (int i = 0; i < 4; i++) begin
            req[i] = (ch_head[i] != ch_tail[i]);
            if (req[i]) ch_data[i] = ch_mem[i][ch_head[i]];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ack_seen[i] && ch_head[i] != ch_tail[i]) ch_head[i]++;
        end
        apply_req();
        ack_seen = ack;
        if (rand_ready) dout_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic bit chans_empty();
        for (int i = 0; i < 4; i++) begin
            if (ch_head[i] != ch_tail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input int budget);
        int n;
        int quiet;
        n     = 0;
        quiet = 0;
        while (quiet < 3 && n < budget) begin
            step();
            n++;
            if (chans_empty() && rd_idx == exp_q.size() && !dout_valid) quiet++;
            else quiet = 0;
        end
        check("drain_done", 32'(quiet >= 3), 32'd1);
    endtask

    task automatic reset_and_check(input string tag);
        rst = 1'b1;
        step();
        check({tag, "_sel"}, 32'(sel), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_valid"}, 32'(dout_valid), 32'd0);
        rst      = 1'b0;
        mdl_last = 3;
    endtask

    // Monitor: every ack must match the next expected capture; held words must not move.
    initial begin
        exp_t         e;
        logic         prev_hold;
        logic [W-1:0] prev_dout;
        prev_hold = 1'b0;
        prev_dout = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ack != 4'b0000) begin
                    if (rd_idx < exp_q.size()) begin
                        e = exp_q[rd_idx];
                        rd_idx++;
                        check("ack_chan", 32'(ack), 32'(4'b0001 << e.ch));
                        check("dout_data", 32'(dout), 32'(e.data));
                        check("valid_on_ack", 32'(dout_valid), 32'd1);
                    end else begin
                        check("unexpected_ack", 32'(ack), 32'd0);
                    end
                end
                if (prev_hold) begin
                    check("hold_valid", 32'(dout_valid), 32'd1);
                    check("hold_dout", 32'(dout), 32'(prev_dout));
                    check("hold_no_ack", 32'(ack), 32'd0);
                end
            end
            prev_hold = dout_valid && !dout_ready && !rst;
            prev_dout = dout;
        end
    end

    initial begin
        logic [W-1:0] d;
        rst        = 1'b1;
        req        = 4'b0000;
        dout_ready = 1'b0;
        rand_ready = 1'b0;
        ack_seen   = 4'b0000;
        mdl_last   = 3;
        for (int i = 0; i < 4; i++) begin
            ch_data[i] = '0;
            ch_head[i] = 0;
            ch_tail[i] = 0;
            mdl_idx[i] = 0;
        end
        step();
        reset_and_check("reset");

        // Single request on channel c.
        dout_ready = 1'b1;
        add_word(2, 8'hA5);
        predict();
        apply_req();
        step();
        check("single_sel", 32'(sel), 32'd2);
        check("single_valid_early", 32'(dout_valid), 32'd0);
        step();
        check("single_dout", 32'(dout), 32'hA5);
        check("single_valid", 32'(dout_valid), 32'd1);
        check("single_ack", 32'(ack), 32'b0100);
        drain(50);

        // All four requesting, two words each.
        reset_and_check("reset2");
        for (int r = 0; r < 2; r++) begin
            add_word(0, 8'h11);
            add_word(1, 8'h22);
            add_word(2, 8'h33);
            add_word(3, 8'h44);
        end
        predict();
        apply_req();
        drain(100);

        // Backpressure, with a competing request arriving during HOLD.
        dout_ready = 1'b0;
        add_word(1, 8'h5A);
        predict();
        apply_req();
        for (int k = 0; k < 10 && !dout_valid; k++) step();
        check("bp_valid", 32'(dout_valid), 32'd1);
        add_word(3, 8'hC3);
        predict();
        apply_req();
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_dout", 32'(dout), 32'h5A);
            check("bp_hold_valid", 32'(dout_valid), 32'd1);
            check("bp_sel", 32'(sel), 32'd1);
        end
        dout_ready = 1'b1;
        step();
        check("bp_consumed", 32'(dout_valid), 32'd0);
        check("bp_next_sel", 32'(sel), 32'd3);
        drain(50);

        // Request on channel b for a single cycle only.
        req        = 4'b0010;
        ch_data[1] = 8'h99;
        step();
        check("wd_sel", 32'(sel), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("wd_valid", 32'(dout_valid), 32'd0);
            check("wd_ack", 32'(ack), 32'd0);
        end

        // Reset while a word is held.
        dout_ready = 1'b0;
        add_word(1, 8'h77);
        predict();
        apply_req();
        for (int k = 0; k < 10 && !dout_valid; k++) step();
        check("rh_dout", 32'(dout), 32'h77);
        step();
        step();
        reset_and_check("rh_reset");
        for (int r = 0; r < 2; r++) begin
            d = W'($urandom);
            add_word(0, d);
            d = W'($urandom);
            add_word(3, d);
        end
        predict();
        apply_req();
        dout_ready = 1'b1;
        drain(100);

        // Random batches with random backpressure.
        rand_ready = 1'b1;
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < 4; i++) begin
                for (int n = $urandom_range(0, 3); n > 0; n--) begin
                    d = W'($urandom);
                    add_word(i, d);
                end
            end
            predict();
            apply_req();
            drain(300);
        end
        check("all_captures_seen", 32'(rd_idx), 32'(exp_q.size()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
